// File: rtl/lamp_seq_pkg.sv
// rtl/lamp_seq_pkg.sv - shared types and constants for the lamp bar segment sequencer
package lamp_seq_pkg;

    localparam int PKG_LAMP_W  = 4;
    localparam int PKG_IDX_W   = 3;
    localparam int PKG_NUM_SEG = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_WAIT,
        S_DONE
    } seq_state_t;

    typedef struct packed {
        logic [PKG_LAMP_W-1:0] target;
        logic [PKG_IDX_W-1:0]  next;
        logic [PKG_IDX_W-1:0]  flick_next;
        logic                  last;
    } seg_entry_t;

    localparam int SEG_ENTRY_W = $bits(seg_entry_t);

    localparam seg_entry_t SEG_DEFAULT = '{
        target:     '0,
        next:       '0,
        flick_next: '0,
        last:       1'b1
    };

endpackage

// File: rtl/lamp_seq_table.sv
// rtl/lamp_seq_table.sv - segment table: synchronous write, asynchronous read, resets to the default entry
module lamp_seq_table
    import lamp_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [PKG_IDX_W-1:0]   waddr,
    input  logic [SEG_ENTRY_W-1:0] wdata,
    input  logic [PKG_IDX_W-1:0]   raddr,
    output logic [SEG_ENTRY_W-1:0] rdata
);

    seg_entry_t mem [PKG_NUM_SEG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PKG_NUM_SEG; i++) begin
                mem[i] <= SEG_DEFAULT;
            end
        end else if (we) begin
            mem[waddr] <= seg_entry_t'(wdata);
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lamp_seq_scheduler.sv
// rtl/lamp_seq_scheduler.sv - table-driven up/down step sequencer; LAMP_SEQ_WATCHDOG_EN adds a completion watchdog
module lamp_seq_scheduler
    import lamp_seq_pkg::*;
#(
    parameter int NUM_LAMP_CODED = PKG_LAMP_W,
    parameter int NUM_SEG        = PKG_NUM_SEG,
    parameter int SEG_IDX_W      = PKG_IDX_W,
    parameter int DIV_W          = 8,
    parameter int WDOG_MAX       = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [SEG_IDX_W-1:0]      cfg_addr,
    input  logic [NUM_LAMP_CODED-1:0] cfg_target,
    input  logic [SEG_IDX_W-1:0]      cfg_next,
    input  logic [SEG_IDX_W-1:0]      cfg_flick_next,
    input  logic                      cfg_last,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      flick,
    input  logic [DIV_W-1:0]          div,
    input  logic [NUM_LAMP_CODED-1:0] lamp_coded,
    output logic                      up,
    output logic                      down,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [SEG_IDX_W-1:0]      seg_idx
);

    seq_state_t             state, state_nxt;
    logic [SEG_IDX_W-1:0]   seg_q, seg_nxt;
    logic [DIV_W-1:0]       divider, divider_nxt;
    seg_entry_t             cur;
    seg_entry_t             wr_entry;
    logic [SEG_ENTRY_W-1:0] rd_bits;
    logic                   seg_complete;
    logic                   wdog_trip;

    assign busy     = (state == S_LOAD) || (state == S_STEP) || (state == S_WAIT);
    assign wr_entry = '{target: cfg_target, next: cfg_next, flick_next: cfg_flick_next, last: cfg_last};

    // The table is frozen for the whole run so the latched entry and successors stay coherent.
    lamp_seq_table u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we && !busy),
        .waddr (cfg_addr),
        .wdata (wr_entry),
        .raddr (seg_q),
        .rdata (rd_bits)
    );

    assign seg_complete = (lamp_coded == cur.target);

`ifdef LAMP_SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_MAX + 1);
    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_trip = (state == S_STEP) && !abort && seg_complete
                       && (wdog_cnt == WDOG_W'(WDOG_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            wdog_cnt <= '0;
        end else if (state == S_STEP && !abort && seg_complete && !wdog_trip) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`else
    assign wdog_trip = 1'b0 & (WDOG_MAX > 0);
`endif

    assign err     = wdog_trip;
    assign seg_idx = seg_q;

    always_comb begin
        state_nxt   = state;
        seg_nxt     = seg_q;
        divider_nxt = divider;
        up          = 1'b0;
        down        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    seg_nxt   = '0;
                end
            end
            S_LOAD: begin
                state_nxt = abort ? S_IDLE : S_STEP;
            end
            S_STEP: begin
                if (abort || wdog_trip) begin
                    state_nxt = S_IDLE;
                end else if (seg_complete) begin
                    if (flick) begin
                        seg_nxt   = cur.flick_next;
                        state_nxt = S_LOAD;
                    end else if (cur.last) begin
                        state_nxt = S_DONE;
                    end else begin
                        seg_nxt   = cur.next;
                        state_nxt = S_LOAD;
                    end
                end else begin
                    up   = (cur.target > lamp_coded);
                    down = !(cur.target > lamp_coded);
                    if (div != '0) begin
                        state_nxt   = S_WAIT;
                        divider_nxt = div;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    divider_nxt = divider - 1'b1;
                    if (divider <= DIV_W'(1)) begin
                        state_nxt = S_STEP;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            seg_q   <= '0;
            divider <= '0;
            cur     <= SEG_DEFAULT;
        end else begin
            state   <= state_nxt;
            seg_q   <= seg_nxt;
            divider <= divider_nxt;
            if (state == S_LOAD) begin
                cur <= seg_entry_t'(rd_bits);
            end
        end
    end

endmodule

// File: tb/tb_lamp_seq_scheduler.sv
// tb/tb_lamp_seq_scheduler.sv - self-checking bench for lamp_seq_scheduler with a lamp datapath model
module tb_lamp_seq_scheduler;

    logic       clk = 1'b0;
    logic       rst, cfg_we, cfg_last, start, abort, flick;
    logic [2:0] cfg_addr, cfg_next, cfg_flick_next;
    logic [3:0] cfg_target;
    logic [7:0] div;
    logic       up, down, busy, done, err;
    logic [2:0] seg_idx;
    logic [3:0] lamp = 4'd0;
    logic       lamp_set;
    logic [3:0] lamp_val;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_times[$];

    typedef struct {
        logic [2:0] addr;
        logic [3:0] target;
        logic [2:0] next;
        logic [2:0] fnext;
        logic       last;
    } cfg_vec_t;

    typedef struct {
        byte kind;
        int  count;
        int  seg;
    } phase_t;

    typedef struct {
        byte kind;
        int  seg;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    byte mon_k;

    always #5 clk = ~clk;

    lamp_seq_scheduler #(.WDOG_MAX(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_target     (cfg_target),
        .cfg_next       (cfg_next),
        .cfg_flick_next (cfg_flick_next),
        .cfg_last       (cfg_last),
        .start          (start),
        .abort          (abort),
        .flick          (flick),
        .div            (div),
        .lamp_coded     (lamp),
        .up             (up),
        .down           (down),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .seg_idx        (seg_idx)
    );

    // Registered lamp level, as the real counter datapath would hold it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lamp_set)  lamp <= lamp_val;
        else if (up)   lamp <= lamp + 4'd1;
        else if (down) lamp <= lamp - 4'd1;
    end

    task automatic check(string name, logic [31:0] act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (up && down) begin
            checks++;
            errors++;
            $display("FAIL up_down_overlap: got up=1 down=1 expected at most one");
        end
        if (up || down || done || err) begin
            mon_k = up ? "U" : down ? "D" : done ? "N" : "E";
            if (up || down) begin
                pulse_cnt++;
                pulse_times.push_back(cyc);
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d seg %0d expected none", mon_k, seg_idx);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", mon_k, mon_e.kind);
                check("event_seg", seg_idx, mon_e.seg);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(cfg_vec_t v);
        cfg_we = 1'b1; cfg_addr = v.addr; cfg_target = v.target;
        cfg_next = v.next; cfg_flick_next = v.fnext; cfg_last = v.last;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_lamp(logic [3:0] v);
        lamp_set = 1'b1; lamp_val = v;
        step();
        lamp_set = 1'b0;
    endtask

    task automatic push_ev(byte k, int seg, int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{kind: k, seg: seg});
    endtask

    task automatic wait_drain(string name, int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_busy"}, busy, 0);
        exp_q.delete();
    endtask

    task automatic wait_seg(int idx, int budget);
        int n = 0;
        while (!(busy && seg_idx == idx) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_seg_reached", (n < budget), 1);
    endtask

    task automatic wait_pulses(int target, int budget);
        int n = 0;
        while (pulse_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_pulses_reached", (n < budget), 1);
    endtask

    task automatic check_idle_outputs(string name);
        check({name, "_up"}, up, 0);
        check({name, "_down"}, down, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_err"}, err, 0);
        check({name, "_seg_idx"}, seg_idx, 0);
    endtask

    cfg_vec_t bounce_cfg[6];
    phase_t   bounce_ph[7];
    phase_t   flick_ph[9];
    int       base, n0;

    initial begin
        bounce_cfg = '{
            '{3'd0, 4'hF, 3'd1, 3'd0, 1'b0},
            '{3'd1, 4'h5, 3'd2, 3'd0, 1'b0},
            '{3'd2, 4'hA, 3'd3, 3'd0, 1'b0},
            '{3'd3, 4'h0, 3'd4, 3'd0, 1'b0},
            '{3'd4, 4'h5, 3'd5, 3'd0, 1'b0},
            '{3'd5, 4'h0, 3'd0, 3'd0, 1'b1}
        };
        bounce_ph = '{
            '{"U", 15, 0}, '{"D", 10, 1}, '{"U", 5, 2}, '{"D", 10, 3},
            '{"U", 5, 4},  '{"D", 5, 5},  '{"N", 1, 5}
        };
        flick_ph = '{
            '{"U", 15, 0}, '{"D", 10, 1}, '{"U", 10, 0}, '{"D", 10, 1},
            '{"U", 5, 2},  '{"D", 10, 3}, '{"U", 5, 4},  '{"D", 5, 5}, '{"N", 1, 5}
        };

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_target = '0; cfg_next = '0;
        cfg_flick_next = '0; cfg_last = 1'b0; start = 1'b0; abort = 1'b0;
        flick = 1'b0; div = '0; lamp_set = 1'b0; lamp_val = '0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Bounce pattern, div=0
        for (int i = 0; i < 6; i++) cfg_write(bounce_cfg[i]);
        for (int i = 0; i < 7; i++) push_ev(bounce_ph[i].kind, bounce_ph[i].seg, bounce_ph[i].count);
        do_start();
        wait_drain("bounce", 400);
        check("bounce_lamp_end", lamp, 0);

        // Flick diverts seg1 back to seg0
        for (int i = 0; i < 9; i++) push_ev(flick_ph[i].kind, flick_ph[i].seg, flick_ph[i].count);
        do_start();
        wait_seg(1, 100);
        step();
        flick = 1'b1;
        wait_seg(0, 100);
        step();
        flick = 1'b0;
        wait_drain("flick", 400);

        // div=3 single segment
        cfg_write('{3'd0, 4'h4, 3'd0, 3'd0, 1'b1});
        div = 8'd3;
        n0 = pulse_times.size();
        push_ev("U", 0, 4);
        push_ev("N", 0, 1);
        do_start();
        wait_drain("div3", 200);
        check("div3_pulse_count", pulse_times.size() - n0, 4);
        if (pulse_times.size() - n0 == 4) begin
            for (int i = 0; i < 3; i++)
                check("div3_interval", pulse_times[n0 + i + 1] - pulse_times[n0 + i], 4);
        end

        // Abort after the third pulse
        set_lamp(4'd0);
        base = pulse_cnt;
        push_ev("U", 0, 3);
        do_start();
        wait_pulses(base + 3, 100);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        repeat (10) step();
        check("abort_no_more_pulses", pulse_cnt - base, 3);
        check("abort_pending", exp_q.size(), 0);
        check("abort_lamp", lamp, 3);
        exp_q.delete();

        // cfg_we while busy must not land
        set_lamp(4'd0);
        div = 8'd0;
        push_ev("U", 0, 4);
        push_ev("N", 0, 1);
        do_start();
        cfg_write('{3'd0, 4'h9, 3'd0, 3'd0, 1'b1});
        wait_drain("busy_write_run", 100);
        push_ev("N", 0, 1);
        do_start();
        wait_drain("readback_run", 100);
        check("readback_lamp", lamp, 4);

        // Reset during WAIT
        set_lamp(4'd0);
        div = 8'd3;
        base = pulse_cnt;
        push_ev("U", 0, 1);
        do_start();
        wait_pulses(base + 1, 100);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("mid_rst");
        check("mid_rst_pending", exp_q.size(), 0);
        exp_q.delete();
        set_lamp(4'd0);
        push_ev("N", 0, 1);
        do_start();
        wait_drain("after_rst", 100);

        // Two-entry cycle under flick
        div = 8'd0;
        cfg_write('{3'd0, 4'h0, 3'd0, 3'd1, 1'b0});
        cfg_write('{3'd1, 4'h0, 3'd0, 3'd0, 1'b0});
        flick = 1'b1;
`ifdef LAMP_SEQ_WATCHDOG_EN
        push_ev("E", 1, 1);
        do_start();
        wait_drain("watchdog", 100);
`else
        do_start();
        repeat (40) step();
        check("cycle_still_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("cycle_abort_busy", busy, 0);
`endif
        flick = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lamp_seq_scheduler.md
Name: lamp_seq_scheduler

Overview:
- Programmable sequencer for the lamp bar counter datapath (4-bit coded lamp level with up/down step inputs).
- Holds a small table of bound segments; each segment has a target level, a normal successor and a flick successor.
- On start, walks the table and drives one-cycle up/down step pulses at a programmable rate until a terminal segment completes.
- Replaces hard-wired bound state machines with a table configured at run time.

Parameters:
- NUM_LAMP_CODED, 4, width of the coded lamp level.
- NUM_SEG, 8, number of segment table entries.
- SEG_IDX_W, 3, segment index width (clog2 of NUM_SEG).
- DIV_W, 8, width of the step-rate divider.
- WDOG_MAX, 64, maximum segment completions per run (watchdog feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  SEG_IDX_W  entry index
- cfg_target  in  NUM_LAMP_CODED  segment bound level
- cfg_next  in  SEG_IDX_W  successor when flick is low
- cfg_flick_next  in  SEG_IDX_W  successor when flick is high
- cfg_last  in  1  terminal entry if flick is low at completion
- start  in  1  run request, starting at entry 0
- abort  in  1  stop the run
- flick  in  1  branch select, sampled at segment completion
- div  in  DIV_W  idle cycles between steps
- lamp_coded  in  NUM_LAMP_CODED  registered level fed back from the datapath
- up  out  1  increment pulse
- down  out  1  decrement pulse
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle watchdog abort pulse
- seg_idx  out  SEG_IDX_W  current entry

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values: up=0, down=0, busy=0, done=0, err=0, seg_idx=0, state=IDLE, divider=0.
- Reset values of every table entry: target=0, next=0, flick_next=0, last=1.
- Reset mid-run forces all of the above on the next edge; the datapath level is not touched.
- FSM states: IDLE, LOAD, STEP, WAIT, DONE.
- IDLE: start=1 → LOAD with seg_idx=0; busy=1 from the next cycle.
- LOAD: latch the entry's fields → STEP.
- STEP, lamp_coded != target: pulse up=1 if target > lamp_coded, else down=1, for exactly one cycle.
  - div=0 → stay in STEP.
  - div>0 → WAIT with divider=div.
  - Step period is div+1 cycles.
- STEP, lamp_coded == target (segment complete), decided in priority order:
  - flick=1 → seg_idx=flick_next, go to LOAD.
  - flick=0 and last=1 → DONE.
  - otherwise → seg_idx=next, go to LOAD.
  - No step pulse is issued in the completion cycle.
- WAIT: decrement the divider; reaching 1 → STEP. The div input is sampled only on entering WAIT.
- DONE: done=1 for one cycle, busy=0 in that same cycle → IDLE.
- up and down are never high together; both are 0 outside STEP.
- abort=1 in any busy state → IDLE next cycle. No done pulse; no pulse issued in that cycle. abort has priority over step and completion.
- cfg_we while busy is ignored. When idle, cfg_we writes the entry at the edge.
- start while busy is ignored. start and cfg_we in the same idle cycle: the write lands first, and the run uses the new entry.
- An already-at-target first segment completes on its first STEP cycle with zero pulses.
- Level compare is unsigned. The scheduler never steps past a target, so no datapath wrap occurs for targets in range.

Optional Feature:
- Macro LAMP_SEQ_WATCHDOG_EN.
- Defined:
  - A per-run counter increments on each segment completion.
  - On reaching WDOG_MAX it acts as abort and pulses err=1 for one cycle.
  - Guards against cyclic tables with flick held high.
- Undefined: no counter; err is tied 0; cyclic tables run until abort or rst.

Decomposition:
- Shared package lamp_seq_pkg holds:
  - FSM state enum.
  - Segment entry struct: target, next, flick_next, last.
  - Default entry constant.
- One natural sub-module, lamp_seq_table: register file with a synchronous write port, an async read port and reset to the default entry.

Test Plan:
- Bounce pattern, div=0, flick=0, lamp_coded starts at 0. Table:
  - seg0: target F, next 1
  - seg1: target 5, next 2
  - seg2: target A, next 3
  - seg3: target 0, next 4
  - seg4: target 5, next 5
  - seg5: target 0, last=1
  - Start → expected: 15 up, 10 down, 5 up, 10 down, 5 up, 5 down pulses; one done pulse; seg_idx sequence 0..5.
- Same table, flick=1 held through seg1's completion (flick_next=0):
  - Expected: seg_idx returns to 0 and 10 further up pulses follow.
- div=3, single segment target 4, last=1 → expected: up pulses exactly 4 cycles apart, 4 pulses, then done.
- abort asserted after the 3rd pulse → expected: no further pulses, busy=0 next cycle, done never pulses. Then cfg_we while busy → entry unchanged on readback run.
- rst during WAIT → expected: all outputs 0 on the next edge, table back to defaults; start then completes immediately with zero pulses (target 0 at level 0).
- With LAMP_SEQ_WATCHDOG_EN, WDOG_MAX=4, two-entry cycle under flick=1 → expected: err pulse on the 4th completion and busy=0. Without the macro, err stays 0.
